// File: rtl/audio_serializer_pkg.sv
// rtl/audio_serializer_pkg.sv - shared helpers for the multichannel audio serializer
package audio_serializer_pkg;

    // Channel index width; a single-channel build still carries a 1-bit index.
    function automatic int ch_bits(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/audio_next_channel.sv
// rtl/audio_next_channel.sv - priority search for the next enabled channel under a mask
// o_next is the lowest enabled channel above i_index (or at it when i_inclusive); o_is_last when none exists.
module audio_next_channel #(
    parameter int CHANNELS = 2,
    parameter int CH_BITS  = 1
) (
    input  logic [CHANNELS-1:0] i_mask,
    input  logic [CH_BITS-1:0]  i_index,
    input  logic                i_inclusive,
    output logic [CH_BITS-1:0]  o_next,
    output logic                o_is_last
);

    always_comb begin
        o_next    = '0;
        o_is_last = 1'b1;
        // Descending scan so the lowest qualifying channel is the final write.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (i_mask[k] && ((k > int'(i_index)) || (i_inclusive && (k == int'(i_index))))) begin
                o_next    = CH_BITS'(k);
                o_is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/multichannel_audio_serializer.sv
// rtl/multichannel_audio_serializer.sv - ping-pong frame buffer emitting one sample per transfer
// Optional per-channel enable mask: AUDIO_SERIALIZER_CHANNEL_MASK_EN.
module multichannel_audio_serializer
    import audio_serializer_pkg::*;
#(
    parameter int  AUDIO_WIDTH = 32,
    parameter int  CHANNELS    = 2,
    localparam int CH_BITS     = ch_bits(CHANNELS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic [CHANNELS*AUDIO_WIDTH-1:0] i_frame,
`ifdef AUDIO_SERIALIZER_CHANNEL_MASK_EN
    input  logic [CHANNELS-1:0]             i_ch_mask,
`endif
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [AUDIO_WIDTH-1:0]          o_audio,
    output logic [CH_BITS-1:0]              o_channel,
    output logic                            o_first,
    output logic                            o_last
);

    typedef struct packed {
        logic [CHANNELS-1:0][AUDIO_WIDTH-1:0] data;
        logic [CHANNELS-1:0]                  mask;
        logic                                 valid;
    } slot_t;

    slot_t r_active;
    slot_t r_pending;
    logic [CH_BITS-1:0] r_channel;
    logic               r_first;

    logic [CHANNELS-1:0][AUDIO_WIDTH-1:0] w_load_data;
    logic [CHANNELS-1:0] w_in_mask;
    logic [CHANNELS-1:0] w_load_mask;
    logic [CH_BITS-1:0]  w_next_ch;
    logic [CH_BITS-1:0]  w_load_ch;
    logic w_act_last, w_load_empty, w_in_nonempty;
    logic w_out_fire, w_last_fire, w_in_fire, w_act_free;

`ifdef AUDIO_SERIALIZER_CHANNEL_MASK_EN
    assign w_in_mask = i_ch_mask;
`else
    assign w_in_mask = '1;
`endif

    assign w_in_nonempty = |w_in_mask;
    assign w_load_data   = r_pending.valid ? r_pending.data : i_frame;
    assign w_load_mask   = r_pending.valid ? r_pending.mask : w_in_mask;

    assign i_ready   = !r_pending.valid;
    assign o_valid   = r_active.valid;
    assign o_audio   = r_active.data[r_channel];
    assign o_channel = r_channel;
    assign o_first   = r_first;
    assign o_last    = w_act_last;

    assign w_out_fire  = r_active.valid && o_ready;
    assign w_last_fire = w_out_fire && w_act_last;
    assign w_in_fire   = i_valid && !r_pending.valid;
    assign w_act_free  = !r_active.valid || w_last_fire;

    audio_next_channel #(.CHANNELS(CHANNELS), .CH_BITS(CH_BITS)) u_active_next (
        .i_mask      (r_active.mask),
        .i_index     (r_channel),
        .i_inclusive (1'b0),
        .o_next      (w_next_ch),
        .o_is_last   (w_act_last)
    );

    audio_next_channel #(.CHANNELS(CHANNELS), .CH_BITS(CH_BITS)) u_load_first (
        .i_mask      (w_load_mask),
        .i_index     ('0),
        .i_inclusive (1'b1),
        .o_next      (w_load_ch),
        .o_is_last   (w_load_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Idle active mask is all ones so o_last reads as a full frame parked at channel 0.
            r_active  <= '{data: '0, mask: '1, valid: 1'b0};
            r_pending <= '0;
            r_channel <= '0;
            r_first   <= 1'b1;
        end else begin
            if (w_act_free && (r_pending.valid || w_in_fire)) begin
                r_active  <= '{data: w_load_data, mask: w_load_mask, valid: !w_load_empty};
                r_channel <= w_load_ch;
                r_first   <= 1'b1;
            end else if (w_last_fire) begin
                r_active.valid <= 1'b0;
                r_channel      <= '0;
                r_first        <= 1'b1;
            end else if (w_out_fire) begin
                r_channel <= w_next_ch;
                r_first   <= 1'b0;
            end

            // Empty-mask frames are consumed here without ever occupying the pending slot.
            if (r_pending.valid && w_act_free) begin
                r_pending.valid <= 1'b0;
            end else if (w_in_fire && !w_act_free && w_in_nonempty) begin
                r_pending <= '{data: i_frame, mask: w_in_mask, valid: 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_multichannel_audio_serializer.sv
// tb/tb_multichannel_audio_serializer.sv - self-checking bench for multichannel_audio_serializer
module tb_multichannel_audio_serializer;

    typedef struct packed {
        logic [3:0] mask;
        int         exp_n;
        int         exp_fc;
        int         exp_lc;
    } vec_t;

    typedef logic [35:0] smp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        d2_i_valid, d2_i_ready, d2_o_valid, d2_o_ready, d2_o_first, d2_o_last;
    logic [63:0] d2_i_frame;
    logic [31:0] d2_o_audio;
    logic        d2_o_channel;
    logic [1:0]  d2_mask;

    logic         d4_i_valid, d4_i_ready, d4_o_valid, d4_o_ready, d4_o_first, d4_o_last;
    logic [127:0] d4_i_frame;
    logic [31:0]  d4_o_audio;
    logic [1:0]   d4_o_channel;
    logic [3:0]   d4_mask;

    int n_checks = 0;
    int n_fail = 0;
    smp_t sb[$];
    logic prev_stall = 1'b0;
    logic [34:0] prev_snap = '0;
    int run_len = 0;
    int max_run = 0;

    always #5 clk = ~clk;

    multichannel_audio_serializer #(.AUDIO_WIDTH(32), .CHANNELS(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (d2_i_valid),
        .i_ready   (d2_i_ready),
        .i_frame   (d2_i_frame),
`ifdef AUDIO_SERIALIZER_CHANNEL_MASK_EN
        .i_ch_mask (d2_mask),
`endif
        .o_valid   (d2_o_valid),
        .o_ready   (d2_o_ready),
        .o_audio   (d2_o_audio),
        .o_channel (d2_o_channel),
        .o_first   (d2_o_first),
        .o_last    (d2_o_last)
    );

    multichannel_audio_serializer #(.AUDIO_WIDTH(32), .CHANNELS(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (d4_i_valid),
        .i_ready   (d4_i_ready),
        .i_frame   (d4_i_frame),
`ifdef AUDIO_SERIALIZER_CHANNEL_MASK_EN
        .i_ch_mask (d4_mask),
`endif
        .o_valid   (d4_o_valid),
        .o_ready   (d4_o_ready),
        .o_audio   (d4_o_audio),
        .o_channel (d4_o_channel),
        .o_first   (d4_o_first),
        .o_last    (d4_o_last)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] rand_frame();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [3:0] eff_mask();
`ifdef AUDIO_SERIALIZER_CHANNEL_MASK_EN
        return d4_mask;
`else
        return 4'hF;
`endif
    endfunction

    task automatic push_frame(input logic [127:0] f, input logic [3:0] m);
        int lo, hi;
        lo = -1;
        hi = -1;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                if (lo < 0) lo = k;
                hi = k;
            end
        end
        for (int k = 0; k < 4; k++)
            if (m[k]) sb.push_back({f[k*32 +: 32], 2'(k), (k == lo), (k == hi)});
    endtask

    // One clock: monitor the 4-channel DUT at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
            run_len = 0;
        end else begin
            if (d4_o_valid) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (prev_stall) chk("hold", {d4_o_valid, d4_o_audio, d4_o_channel}, prev_snap);
            prev_stall = d4_o_valid && !d4_o_ready;
            prev_snap = {d4_o_valid, d4_o_audio, d4_o_channel};
            if (d4_o_valid && d4_o_ready) begin
                chk("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0)
                    chk("sample", {d4_o_audio, d4_o_channel, d4_o_first, d4_o_last}, sb.pop_front());
            end
            if (d4_i_valid && d4_i_ready) push_frame(d4_i_frame, eff_mask());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] f, input logic [3:0] m);
        int t;
        logic acc;
        t = 0;
        acc = 1'b0;
        d4_i_frame = f;
        d4_mask = m;
        d4_i_valid = 1'b1;
        while (!acc && t < 200) begin
            acc = d4_i_ready;
            tick();
            t++;
        end
        d4_i_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        d4_i_valid = 1'b0;
        d4_o_ready = 1'b1;
        while (sb.size() > 0 && t < 200) begin
            tick();
            t++;
        end
        repeat (3) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        vec_t vt[5];
        logic [127:0] fa, fc5;
        int n, fch, lch, sent, t;
        logic ir, acc;

`ifdef AUDIO_SERIALIZER_CHANNEL_MASK_EN
        vt[0] = '{4'b1111, 4, 0, 3};
        vt[1] = '{4'b1010, 2, 1, 3};
        vt[2] = '{4'b0100, 1, 2, 2};
        vt[3] = '{4'b0000, 0, 0, 0};
        vt[4] = '{4'b1001, 2, 0, 3};
`else
        vt[0] = '{4'b1111, 4, 0, 3};
        vt[1] = '{4'b1010, 4, 0, 3};
        vt[2] = '{4'b0100, 4, 0, 3};
        vt[3] = '{4'b0000, 4, 0, 3};
        vt[4] = '{4'b1001, 4, 0, 3};
`endif

        d2_i_valid = 1'b0; d2_o_ready = 1'b0; d2_i_frame = '0; d2_mask = 2'b11;
        d4_i_valid = 1'b0; d4_o_ready = 1'b0; d4_i_frame = '0; d4_mask = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_d2", {d2_o_valid, d2_i_ready, d2_o_channel, d2_o_audio, d2_o_first, d2_o_last},
            {1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0});
        chk("rst_d4", {d4_o_valid, d4_i_ready, d4_o_channel, d4_o_audio, d4_o_first, d4_o_last},
            {1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b0});

        // Stereo frame: ch0 then ch1 on consecutive cycles.
        d2_o_ready = 1'b1;
        d2_i_frame = {32'hBBBB, 32'hAAAA};
        d2_i_valid = 1'b1;
        tick();
        d2_i_valid = 1'b0;
        chk("t1_c1", {d2_o_valid, d2_o_channel, d2_o_audio, d2_o_first, d2_o_last},
            {1'b1, 1'b0, 32'hAAAA, 1'b1, 1'b0});
        tick();
        chk("t1_c2", {d2_o_valid, d2_o_channel, d2_o_audio, d2_o_first, d2_o_last},
            {1'b1, 1'b1, 32'hBBBB, 1'b0, 1'b1});
        tick();
        chk("t1_idle", d2_o_valid, 0);

        // Back-to-back frames must stream without bubbles.
        d4_o_ready = 1'b1;
        max_run = 0;
        for (int f = 0; f < 3; f++) send(rand_frame(), 4'hF);
        repeat (14) tick();
        chk("t2_run", max_run, 12);
        chk("t2_sb", sb.size(), 0);

        // Stalled sink: both slots fill, third frame is held off.
        d4_o_ready = 1'b0;
        fa = rand_frame();
        send(fa, 4'hF);
        send(rand_frame(), 4'hF);
        chk("t3_full", d4_i_ready, 0);
        fc5 = rand_frame();
        d4_i_frame = fc5;
        d4_mask = 4'hF;
        d4_i_valid = 1'b1;
        repeat (4) begin
            tick();
            chk("t3_hold", {d4_i_ready, d4_o_valid, d4_o_channel, d4_o_audio},
                {1'b0, 1'b1, 2'd0, fa[31:0]});
        end
        d4_o_ready = 1'b1;
        send(fc5, 4'hF);
        drain();

        // Mask vectors, one frame each with a ready sink.
        d4_o_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(rand_frame(), vt[i].mask);
            n = 0; fch = 0; lch = 0; ir = 1'b1;
            repeat (8) begin
                if (d4_o_valid) begin
                    if (n == 0) fch = int'(d4_o_channel);
                    lch = int'(d4_o_channel);
                    n++;
                end
                ir = ir & d4_i_ready;
                tick();
            end
            chk("vec_n", n, vt[i].exp_n);
            if (vt[i].exp_n > 0) begin
                chk("vec_first", fch, vt[i].exp_fc);
                chk("vec_last", lch, vt[i].exp_lc);
            end
            chk("vec_irdy", ir, 1);
        end
        drain();

        // Random valid/ready traffic against the scoreboard.
        sent = 0;
        t = 0;
        d4_i_valid = 1'b0;
        while ((sent < 2000 || d4_i_valid) && t < 40000) begin
            if (!d4_i_valid && sent < 2000 && $urandom_range(0, 3) != 0) begin
                d4_i_valid = 1'b1;
                d4_i_frame = rand_frame();
                d4_mask = 4'($urandom());
            end
            d4_o_ready = ($urandom_range(0, 3) != 0);
            acc = d4_i_valid && d4_i_ready;
            tick();
            t++;
            if (acc) begin
                sent++;
                d4_i_valid = 1'b0;
            end
        end
        chk("t4_sent", sent, 2000);
        drain();

        // Reset in the middle of a frame.
        d4_o_ready = 1'b1;
        send(rand_frame(), 4'hF);
        t = 0;
        while (!(d4_o_valid && d4_o_channel == 2'd2) && t < 20) begin
            tick();
            t++;
        end
        chk("t5_at_ch2", {d4_o_valid, d4_o_channel}, {1'b1, 2'd2});
        reset = 1'b1;
        #1;
        chk("t5_rst", {d4_o_valid, d4_i_ready, d4_o_channel}, {1'b0, 1'b1, 2'd0});
        tick();
        tick();
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk("t5_idle", d4_o_valid, 0);
        end
        fc5 = rand_frame();
        send(fc5, 4'hF);
        chk("t5_restart", {d4_o_valid, d4_o_channel, d4_o_first, d4_o_audio},
            {1'b1, 2'd0, 1'b1, fc5[31:0]});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
